// File: rtl/lane_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lane_pkg
// Description : Shared state/status encodings and the default lane centre.
// Revision    : 1.0 - initial release
// ============================================================================
package lane_pkg;

    typedef enum logic [1:0] {
        STATUS_LOCKED = 2'd0,
        STATUS_HOLD   = 2'd1,
        STATUS_LOST   = 2'd2
    } lane_status_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECEIVE = 3'd1,
        S_SELECT  = 3'd2,
        S_CALC    = 3'd3,
        S_OUTPUT  = 3'd4
    } lane_state_t;

    // Middle of the gradient position range 0..ROW_LEN-3
    function automatic int center_default(input int row_len);
        return (row_len - 2) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_peak_collector.sv
`default_nettype none
// ============================================================================
// Module      : lane_peak_collector
// Description : Streams a pixel row, forms i/i-2 gradients and records edge peaks.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_peak_collector
    import lane_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int ROW_LEN   = 32,
    parameter int MAX_PEAKS = 4,
    parameter int THRESHOLD = 100,
    parameter int MIN_GAP   = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      clear,
    input  logic                                      beat,
    input  logic [PIX_W-1:0]                          pix,
    output logic                                      last_beat,
    output logic [MAX_PEAKS-1:0][$clog2(ROW_LEN)-1:0] peak_pos,
    output logic [MAX_PEAKS-1:0][PIX_W-1:0]           peak_val,
    output logic [$clog2(MAX_PEAKS+1)-1:0]            peak_cnt
);

    localparam int POS_W = $clog2(ROW_LEN);
    localparam int CNT_W = $clog2(MAX_PEAKS + 1);

    logic [POS_W-1:0]                  r_idx;
    logic [PIX_W-1:0]                  r_pix1;
    logic [PIX_W-1:0]                  r_pix2;
    logic [MAX_PEAKS-1:0][POS_W-1:0]   r_pos;
    logic [MAX_PEAKS-1:0][PIX_W-1:0]   r_val;
    logic [CNT_W-1:0]                  r_cnt;

    logic [PIX_W:0]   w_grad;
    logic [PIX_W:0]   w_neg;
    logic [PIX_W-1:0] w_mag;
    logic [POS_W-1:0] w_k;
    logic [POS_W-1:0] w_last_pos;
    logic [PIX_W-1:0] w_last_val;
    logic [POS_W-1:0] w_gap;
    logic             w_far;
    logic             w_cand;
    logic             w_push;
    logic             w_over;

    assign w_grad    = {1'b0, pix} - {1'b0, r_pix2};
    assign w_neg     = -w_grad;
    assign w_mag     = w_grad[PIX_W] ? w_neg[PIX_W-1:0] : w_grad[PIX_W-1:0];
    assign w_k       = r_idx - POS_W'(2);
    assign last_beat = beat && (r_idx == POS_W'(ROW_LEN - 1));

    always_comb begin
        w_last_pos = '0;
        w_last_val = '0;
        for (int j = 0; j < MAX_PEAKS; j++) begin
            if (CNT_W'(j + 1) == r_cnt) begin
                w_last_pos = r_pos[j];
                w_last_val = r_val[j];
            end
        end
    end

    // Positions only grow within a row, so the unsigned gap never wraps
    assign w_gap  = w_k - w_last_pos;
    assign w_far  = (w_gap >= POS_W'(MIN_GAP));
    assign w_cand = beat && (r_idx >= POS_W'(2)) && (w_mag > PIX_W'(THRESHOLD));
    assign w_push = w_cand && ((r_cnt == '0) || (w_far && (r_cnt < CNT_W'(MAX_PEAKS))));
    assign w_over = w_cand && (r_cnt != '0) && !w_far && (w_mag > w_last_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_pix1 <= '0;
            r_pix2 <= '0;
            r_pos  <= '0;
            r_val  <= '0;
            r_cnt  <= '0;
        end else if (clear) begin
            r_idx  <= '0;
            r_pix1 <= '0;
            r_pix2 <= '0;
            r_pos  <= '0;
            r_val  <= '0;
            r_cnt  <= '0;
        end else if (beat) begin
            r_idx  <= r_idx + POS_W'(1);
            r_pix2 <= r_pix1;
            r_pix1 <= pix;
            if (w_push) begin
                for (int j = 0; j < MAX_PEAKS; j++) begin
                    if (CNT_W'(j) == r_cnt) begin
                        r_pos[j] <= w_k;
                        r_val[j] <= w_mag;
                    end
                end
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_over) begin
                for (int j = 0; j < MAX_PEAKS; j++) begin
                    if (CNT_W'(j + 1) == r_cnt) begin
                        r_pos[j] <= w_k;
                        r_val[j] <= w_mag;
                    end
                end
            end
        end
    end

    assign peak_pos = r_pos;
    assign peak_val = r_val;
    assign peak_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/lane_center_tracker.sv
`default_nettype none
// ============================================================================
// Module      : lane_center_tracker
// Description : Picks the edge pair closest to the previous lane centre per row.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_center_tracker
    import lane_pkg::*;
#(
    parameter int PIX_W       = 8,
    parameter int ROW_LEN     = 32,
    parameter int MAX_PEAKS   = 4,
    parameter int THRESHOLD   = 100,
    parameter int MIN_GAP     = 4,
    parameter int HOLD_FRAMES = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       smooth_en,
    input  logic [PIX_W-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [$clog2(ROW_LEN)-1:0] center,
    output logic [PIX_W-1:0]           confidence,
    output logic [1:0]                 status,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int POS_W  = $clog2(ROW_LEN);
    localparam int CNT_W  = $clog2(MAX_PEAKS + 1);
    localparam int SLOT_W = (MAX_PEAKS > 2) ? $clog2(MAX_PEAKS) : 1;
    localparam int LOST_W = $clog2(HOLD_FRAMES + 2);

    localparam logic [POS_W-1:0]  c_center_default = POS_W'(center_default(ROW_LEN));
    localparam logic [SLOT_W-1:0] c_last_p1        = SLOT_W'(MAX_PEAKS - 2);
    localparam logic [SLOT_W-1:0] c_last_slot      = SLOT_W'(MAX_PEAKS - 1);

    lane_state_t r_state;
    lane_state_t w_state_next;

    logic                            w_beat;
    logic                            w_clear;
    logic                            w_last_beat;
    logic [MAX_PEAKS-1:0][POS_W-1:0] w_peak_pos;
    logic [MAX_PEAKS-1:0][PIX_W-1:0] w_peak_val;
    logic [CNT_W-1:0]                w_peak_cnt;

    logic [SLOT_W-1:0] r_p1;
    logic [SLOT_W-1:0] r_p2;
    logic              r_found;
    logic [POS_W-1:0]  r_best_c;
    logic [POS_W-1:0]  r_best_diff;
    logic [PIX_W-1:0]  r_best_conf;
    logic [POS_W-1:0]  r_last_center;
    logic [LOST_W-1:0] r_lost_cnt;
    logic [POS_W-1:0]  r_center;
    logic [PIX_W-1:0]  r_conf;
    lane_status_t      r_status;

    assign in_ready  = (r_state == S_RECEIVE);
    assign out_valid = (r_state == S_OUTPUT);
    assign w_beat    = in_valid && in_ready;
    assign w_clear   = (r_state == S_IDLE) && start;

    lane_peak_collector #(
        .PIX_W     (PIX_W),
        .ROW_LEN   (ROW_LEN),
        .MAX_PEAKS (MAX_PEAKS),
        .THRESHOLD (THRESHOLD),
        .MIN_GAP   (MIN_GAP)
    ) u_collector (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .beat      (w_beat),
        .pix       (in_data),
        .last_beat (w_last_beat),
        .peak_pos  (w_peak_pos),
        .peak_val  (w_peak_val),
        .peak_cnt  (w_peak_cnt)
    );

    // Current pair under evaluation
    logic [POS_W-1:0] w_pos1, w_pos2;
    logic [PIX_W-1:0] w_val1, w_val2;
    logic             w_pair_ok;
    logic [POS_W:0]   w_pos_sum;
    logic [POS_W-1:0] w_pair_c;
    logic [POS_W-1:0] w_pair_diff;
    logic [PIX_W:0]   w_val_sum;
    logic             w_take;
    logic             w_last_pair;
    logic [POS_W:0]   w_smooth_sum;
    logic [POS_W-1:0] w_meas_out;

    assign w_pos1      = w_peak_pos[r_p1];
    assign w_pos2      = w_peak_pos[r_p2];
    assign w_val1      = w_peak_val[r_p1];
    assign w_val2      = w_peak_val[r_p2];
    assign w_pair_ok   = (CNT_W'(r_p2) < w_peak_cnt);
    assign w_pos_sum   = {1'b0, w_pos1} + {1'b0, w_pos2};
    assign w_pair_c    = w_pos_sum[POS_W:1];
    assign w_pair_diff = (w_pair_c >= r_last_center) ? (w_pair_c - r_last_center)
                                                     : (r_last_center - w_pair_c);
    assign w_val_sum   = {1'b0, w_val1} + {1'b0, w_val2};
    assign w_take      = w_pair_ok && (!r_found || (w_pair_diff < r_best_diff));
    assign w_last_pair = (r_p1 == c_last_p1);

    assign w_smooth_sum = {1'b0, r_last_center} + {1'b0, r_best_c} + (POS_W+1)'(1);
    assign w_meas_out   = smooth_en ? w_smooth_sum[POS_W:1] : r_best_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (start)       w_state_next = S_RECEIVE;
            S_RECEIVE: if (w_last_beat) w_state_next = S_SELECT;
            S_SELECT:  if (w_last_pair) w_state_next = S_CALC;
            S_CALC:                     w_state_next = S_OUTPUT;
            S_OUTPUT:  if (out_ready)   w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1          <= '0;
            r_p2          <= SLOT_W'(1);
            r_found       <= 1'b0;
            r_best_c      <= '0;
            r_best_diff   <= '0;
            r_best_conf   <= '0;
            r_last_center <= c_center_default;
            r_lost_cnt    <= '0;
            r_center      <= '0;
            r_conf        <= '0;
            r_status      <= STATUS_LOST;
        end else begin
            case (r_state)
                S_RECEIVE: begin
                    r_p1    <= '0;
                    r_p2    <= SLOT_W'(1);
                    r_found <= 1'b0;
                end
                S_SELECT: begin
                    if (w_take) begin
                        r_found     <= 1'b1;
                        r_best_c    <= w_pair_c;
                        r_best_diff <= w_pair_diff;
                        r_best_conf <= w_val_sum[PIX_W:1];
                    end
                    // Walk (p1,p2) in lexicographic order, p1 < p2
                    if (r_p2 == c_last_slot) begin
                        r_p1 <= r_p1 + SLOT_W'(1);
                        r_p2 <= r_p1 + SLOT_W'(2);
                    end else begin
                        r_p2 <= r_p2 + SLOT_W'(1);
                    end
                end
                S_CALC: begin
                    if (r_found) begin
                        r_center      <= w_meas_out;
                        r_last_center <= w_meas_out;
                        r_conf        <= r_best_conf;
                        r_status      <= STATUS_LOCKED;
                        r_lost_cnt    <= '0;
                    end else if (r_lost_cnt < LOST_W'(HOLD_FRAMES)) begin
                        r_center   <= r_last_center;
                        r_conf     <= '0;
                        r_status   <= STATUS_HOLD;
                        r_lost_cnt <= r_lost_cnt + LOST_W'(1);
                    end else begin
                        r_center      <= c_center_default;
                        r_last_center <= c_center_default;
                        r_conf        <= '0;
                        r_status      <= STATUS_LOST;
                    end
                end
                default: ;
            endcase
        end
    end

    assign center     = r_center;
    assign confidence = r_conf;
    assign status     = r_status;

endmodule
`default_nettype wire
